// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared constants for the iterative multiply/divide unit: operation
// encodings, FSM state encodings, the iteration count, and a small helper
// that forms operand magnitudes.
// -----------------------------------------------------------------------------
package muldiv_pkg;

   // Number of shift steps per operation (one bit per cycle, 32-bit operands).
   localparam int ITER = 32;

   // Counter value of the final CALC step.
   localparam logic [4:0] LAST_ITER = 5'(ITER - 1);

   // Operation select encodings, shared by the datapath and control decode.
   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   // FSM state encodings.
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_FIX  = 2'd2;

   // Magnitude of a 32-bit operand. Signed operands are replaced by their
   // two's-complement absolute value; 0x80000000 maps to itself, which is
   // the correct unsigned magnitude 2^31.
   function automatic logic [31:0] abs32(input logic [31:0] v, input logic use_sign);
      return (use_sign && v[31]) ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative MULT/MULTU/DIV/DIVU unit with private HI/LO registers. Operands
// are reduced to magnitudes at launch, processed for 32 cycles on a shared
// 64-bit shift register (shift-add multiply or restoring divide), and signs
// are applied in a single fix-up cycle that also writes HI/LO.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   start        launch request, honoured only while idle
//   op           00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   reg1content  rs operand (multiplicand / dividend)
//   reg2content  rt operand (multiplier / divisor)
//   hiWflag      MTHI write enable (idle, no start)
//   loWflag      MTLO write enable (idle, no start)
//   wdata        MTHI/MTLO write data
//   busy         operation in progress
//   done         one-cycle pulse after HI/LO receive a result
//   hi, lo       HI and LO registers
// -----------------------------------------------------------------------------
module muldiv_unit
   import muldiv_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] reg1content,
   input  logic [31:0] reg2content,
   input  logic        hiWflag,
   input  logic        loWflag,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   logic [1:0]  state;
   logic [4:0]  cnt;
   logic        is_div_q;     // latched op class: divide vs multiply
   logic        neg_main_q;   // negate product / quotient at fix-up
   logic        neg_rem_q;    // negate remainder at fix-up (negative dividend)
   logic        div_zero_q;   // divisor was zero
   logic [31:0] opnd_q;       // multiplicand magnitude or divisor magnitude
   logic [63:0] acc;          // {partial product | remainder, multiplier | quotient}
   logic [31:0] hi_q;
   logic [31:0] lo_q;
   logic        done_q;

   // ---------------------------------------------------------------- decode
   logic        is_div_in;
   logic        is_signed_in;
   logic [31:0] mag_a;
   logic [31:0] mag_b;

   assign is_div_in    = (op == OP_DIV)  || (op == OP_DIVU);
   assign is_signed_in = (op == OP_MULT) || (op == OP_DIV);
   assign mag_a        = abs32(reg1content, is_signed_in);
   assign mag_b        = abs32(reg2content, is_signed_in);

   // -------------------------------------------------------------- datapath
   // Multiply step: add the multiplicand into the upper half when the current
   // multiplier LSB is set, then shift the 65-bit {carry, acc} right by one.
   logic [32:0] mul_sum;
   logic [63:0] mul_next;

   assign mul_sum  = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? opnd_q : 32'd0)};
   assign mul_next = {mul_sum, acc[31:1]};

   // Restoring divide step: shift the next dividend bit into the remainder,
   // trial-subtract the divisor, keep the difference only if it did not
   // borrow. The quotient bit enters at the bottom as dividend bits leave.
   // A zero divisor never borrows, so the quotient becomes all ones and the
   // remainder collects the dividend unchanged.
   logic [33:0] div_trial;
   logic        div_ok;
   logic [63:0] div_next;

   assign div_trial = {1'b0, acc[63:31]} - {2'b00, opnd_q};
   assign div_ok    = ~div_trial[33];
   assign div_next  = {(div_ok ? div_trial[31:0] : acc[62:31]), acc[30:0], div_ok};

   // ----------------------------------------------------------- sign fix-up
   logic [63:0] prod;
   logic [31:0] quo;
   logic [31:0] rem;
   logic [31:0] fix_hi;
   logic [31:0] fix_lo;

   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so
      // no path leaves a value unassigned and no latch is inferred.
      prod   = neg_main_q ? (~acc + 64'd1) : acc;
      quo    = acc[31:0];
      rem    = acc[63:32];
      fix_hi = prod[63:32];
      fix_lo = prod[31:0];
      if (is_div_q) begin
         fix_hi = neg_rem_q ? (~rem + 32'd1) : rem;
         if (div_zero_q)
            fix_lo = 32'hFFFF_FFFF;
         else
            fix_lo = neg_main_q ? (~quo + 32'd1) : quo;
      end
   end

   // -------------------------------------------------------------- sequencer
   // NOTE: all state below uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         is_div_q   <= 1'b0;
         neg_main_q <= 1'b0;
         neg_rem_q  <= 1'b0;
         div_zero_q <= 1'b0;
         opnd_q     <= '0;
         acc        <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  // Launch wins over a simultaneous MTHI/MTLO write.
                  is_div_q   <= is_div_in;
                  neg_main_q <= is_signed_in & (reg1content[31] ^ reg2content[31]);
                  neg_rem_q  <= is_signed_in & reg1content[31];
                  div_zero_q <= is_div_in & (reg2content == 32'd0);
                  opnd_q     <= is_div_in ? mag_b : mag_a;
                  acc        <= {32'd0, (is_div_in ? mag_a : mag_b)};
                  cnt        <= '0;
                  state      <= ST_CALC;
               end else begin
                  if (hiWflag) hi_q <= wdata;
                  if (loWflag) lo_q <= wdata;
               end
            end
            ST_CALC: begin
               acc <= is_div_q ? div_next : mul_next;
               cnt <= cnt + 5'd1;
               if (cnt == LAST_ITER)
                  state <= ST_FIX;
            end
            ST_FIX: begin
               hi_q   <= fix_hi;
               lo_q   <= fix_lo;
               done_q <= 1'b1;
               state  <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign busy = (state != ST_IDLE);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
// Self-checking bench for muldiv_unit: a table of directed operations with
// hand-computed HI/LO results, followed by hand-written sequences for
// MTHI/MTLO, ignored requests while busy, start-vs-write priority,
// back-to-back launch and reset mid-operation. Inputs change and outputs
// are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;
   import muldiv_pkg::*;

   logic        clk;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] reg1content;
   logic [31:0] reg2content;
   logic        hiWflag;
   logic        loWflag;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   muldiv_unit dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .op          (op),
      .reg1content (reg1content),
      .reg2content (reg2content),
      .hiWflag     (hiWflag),
      .loWflag     (loWflag),
      .wdata       (wdata),
      .busy        (busy),
      .done        (done),
      .hi          (hi),
      .lo          (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
      string       name;
   } vec_t;

   vec_t vq[$];
   int   tests;
   int   fails;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic add(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] eh, input logic [31:0] el, input string name);
      vec_t v;
      v.op = o; v.a = a; v.b = b; v.exp_hi = eh; v.exp_lo = el; v.name = name;
      vq.push_back(v);
   endtask

   // Called on a falling edge: presents a launch for one cycle, then scrambles
   // the operand buses to confirm the unit captured them at launch.
   task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      start       = 1'b1;
      op          = o;
      reg1content = a;
      reg2content = b;
      @(negedge clk);
      start       = 1'b0;
      reg1content = ~a;
      reg2content = ~b ^ 32'h0F0F_0F0F;
   endtask

   // Waits (bounded) until done is seen on a falling edge, counting the
   // falling edges at which busy was high on the way.
   task automatic wait_done(output int busy_cycles, output bit got);
      busy_cycles = 0;
      got         = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (done) begin
            got = 1'b1;
            break;
         end
         if (busy) busy_cycles++;
         @(negedge clk);
      end
   endtask

   initial begin
      int bc;
      bit got;
      bit seen_activity;

      tests = 0;
      fails = 0;
      rst = 1'b1; start = 1'b0; op = OP_MULT; reg1content = '0; reg2content = '0;
      hiWflag = 1'b0; loWflag = 1'b0; wdata = '0;

      // ------------------------------------------------------------ vectors
      add(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
      add(OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_m3x7");
      add(OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "mult_min_sq");
      add(OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, "mult_m1xm1");
      add(OP_MULT,  32'h0000_3039, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_CFC7, "mult_12345xm1");
      add(OP_MULTU, 32'h0000_0005, 32'h0000_0006, 32'h0000_0000, 32'h0000_001E, "multu_5x6");
      add(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7d2");
      add(OP_DIVU,  32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, "divu_7d2");
      add(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_min_m1");
      add(OP_DIV,   32'h0000_0064, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2, "div_100dm7");
      add(OP_DIVU,  32'hFFFF_FFFF, 32'h0000_000A, 32'h0000_0005, 32'h1999_9999, "divu_maxd10");
      add(OP_DIVU,  32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, "divu_by0");
      add(OP_DIV,   32'hFFFF_FF9C, 32'h0000_0000, 32'hFFFF_FF9C, 32'hFFFF_FFFF, "div_neg_by0");

      // -------------------------------------------------------------- reset
      repeat (3) @(negedge clk);
      check("reset_hi",   hi, 32'd0);
      check("reset_lo",   lo, 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // -------------------------------------------------------- table loop
      for (int i = 0; i < vq.size(); i++) begin
         launch(vq[i].op, vq[i].a, vq[i].b);
         wait_done(bc, got);
         check({vq[i].name, "_done"},  32'(got), 32'd1);
         check({vq[i].name, "_busy"},  32'(bc), 32'd33);
         check({vq[i].name, "_hi"},    hi, vq[i].exp_hi);
         check({vq[i].name, "_lo"},    lo, vq[i].exp_lo);
         @(negedge clk);
         check({vq[i].name, "_pulse"}, 32'(done), 32'd0);
      end

      // ------------------------------------------------------- MTHI / MTLO
      hiWflag = 1'b1; wdata = 32'h1234_5678;
      @(negedge clk);
      hiWflag = 1'b0;
      check("mthi", hi, 32'h1234_5678);
      loWflag = 1'b1; wdata = 32'hCAFE_F00D;
      @(negedge clk);
      loWflag = 1'b0;
      check("mtlo", lo, 32'hCAFE_F00D);

      // ------------------------- MTLO and second start while busy: ignored
      launch(OP_DIVU, 32'd7, 32'd2);
      repeat (5) @(negedge clk);
      check("calc_hi_stable", hi, 32'h1234_5678);
      check("calc_lo_stable", lo, 32'hCAFE_F00D);
      loWflag = 1'b1; wdata = 32'hDEAD_BEEF;
      start = 1'b1; op = OP_MULTU; reg1content = 32'd9; reg2content = 32'd9;
      @(negedge clk);
      loWflag = 1'b0; start = 1'b0;
      check("busy_mtlo_ignored", lo, 32'hCAFE_F00D);
      wait_done(bc, got);
      check("busy_ign_done", 32'(got), 32'd1);
      check("busy_ign_hi", hi, 32'd1);
      check("busy_ign_lo", lo, 32'd3);
      @(negedge clk);
      check("busy_ign_no_relaunch", 32'(busy), 32'd0);

      // --------------------------------------- start together with MTHI
      start = 1'b1; hiWflag = 1'b1; wdata = 32'hAAAA_5555;
      op = OP_MULTU; reg1content = 32'd5; reg2content = 32'd6;
      @(negedge clk);
      start = 1'b0; hiWflag = 1'b0;
      check("start_wins_hi", hi, 32'd1);
      wait_done(bc, got);
      check("start_wins_done", 32'(got), 32'd1);
      check("start_wins_res_hi", hi, 32'd0);
      check("start_wins_res_lo", lo, 32'd30);

      // ---------------------------- back-to-back launch in the done cycle
      launch(OP_DIVU, 32'd30, 32'd4);
      check("b2b_done_drop", 32'(done), 32'd0);
      check("b2b_busy", 32'(busy), 32'd1);
      wait_done(bc, got);
      check("b2b_got", 32'(got), 32'd1);
      check("b2b_latency", 32'(bc), 32'd33);
      check("b2b_hi", hi, 32'd2);
      check("b2b_lo", lo, 32'd7);
      @(negedge clk);

      // ------------------------------------------------ reset mid-operation
      launch(OP_MULTU, 32'd5, 32'd6);
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_mid_hi",   hi, 32'd0);
      check("rst_mid_lo",   lo, 32'd0);
      check("rst_mid_busy", 32'(busy), 32'd0);
      check("rst_mid_done", 32'(done), 32'd0);
      seen_activity = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (done || busy) seen_activity = 1'b1;
      end
      check("rst_mid_quiet", 32'(seen_activity), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
